// File: rtl/conv3x3_sequencer.sv
// 3x3 valid-convolution address/tap sequencer.
// Issues 9 taps per output pixel and tags products for the accumulator.
module conv3x3_sequencer #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 6,
  parameter int OADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  img_addr,
  output logic [3:0]         wgt_addr,
  output logic               mac_valid,
  output logic               acc_first,
  output logic               acc_last,
  output logic               out_we,
  output logic [OADDR_W-1:0] out_addr
);

  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_C = CW'(OUT_W - 1);
  localparam logic [RW-1:0] LAST_R = RW'(OUT_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_n;

  logic [3:0]         tap;
  logic [1:0]         kc;
  logic [CW-1:0]      ocol;
  logic [RW-1:0]      orow;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  off;
  logic [OADDR_W-1:0] pix;
  logic [OADDR_W-1:0] mac_pix;
  logic               mac_end;
  logic               issue;
  logic               tap_end;
  logic               frame_end;

  assign issue     = (state == RUN) && !hold;
  assign tap_end   = (tap == 4'd8);
  assign frame_end = tap_end && (ocol == LAST_C) && (orow == LAST_R);
  assign rd_en     = issue;
  assign busy      = (state != IDLE);
  assign wgt_addr  = tap;
  assign img_addr  = base + off;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (issue && frame_end) state_n = DRAIN;
      DRAIN:   if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // base tracks the window origin, off the tap offset inside the window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap  <= '0;
      kc   <= '0;
      off  <= '0;
      base <= '0;
      ocol <= '0;
      orow <= '0;
      pix  <= '0;
    end else if (issue) begin
      if (tap_end) begin
        tap <= '0;
        kc  <= '0;
        off <= '0;
        if (frame_end) begin
          base <= '0;
          ocol <= '0;
          orow <= '0;
          pix  <= '0;
        end else begin
          pix <= pix + 1'b1;
          if (ocol == LAST_C) begin
            ocol <= '0;
            orow <= orow + 1'b1;
            base <= base + ADDR_W'(3);
          end else begin
            ocol <= ocol + 1'b1;
            base <= base + 1'b1;
          end
        end
      end else begin
        tap <= tap + 1'b1;
        if (kc == 2'd2) begin
          kc  <= '0;
          off <= off + ADDR_W'(IMG_W - 2);
        end else begin
          kc  <= kc + 1'b1;
          off <= off + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_valid <= 1'b0;
      acc_first <= 1'b0;
      acc_last  <= 1'b0;
      mac_pix   <= '0;
      mac_end   <= 1'b0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      mac_valid <= issue;
      acc_first <= issue && (tap == 4'd0);
      acc_last  <= issue && tap_end;
      mac_pix   <= pix;
      mac_end   <= issue && frame_end;
      out_we    <= mac_valid && acc_last;
      done      <= mac_end;
      if (mac_valid && acc_last) out_addr <= mac_pix;
    end
  end

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Scoreboard bench for conv3x3_sequencer: reference model from tap
// arithmetic, randomized hold stalls, abort and restart scenarios.
module tb_conv3x3_sequencer;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int OW = W - 2;
  localparam int OH = H - 2;
  localparam int T  = 9 * OW * OH;

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
  } ent_t;

  logic       clk = 0;
  logic       rst = 0;
  logic       start = 0;
  logic       hold = 0;
  logic       busy, done, rd_en;
  logic [5:0] img_addr;
  logic [3:0] wgt_addr;
  logic       mac_valid, acc_first, acc_last, out_we;
  logic [5:0] out_addr;

  logic       start2 = 0;
  logic       hold2 = 0;
  logic       s_busy, s_done, s_rd_en;
  logic [3:0] s_img_addr;
  logic [3:0] s_wgt_addr;
  logic       s_mac_valid, s_acc_first, s_acc_last, s_out_we;
  logic [0:0] s_out_addr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frame_s = 0;
  int frame_done = 0;
  bit active = 0;

  ent_t qi[$];
  ent_t qt[$];
  ent_t qw[$];

  conv3x3_sequencer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(6), .OADDR_W(6)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .rd_en(rd_en),
    .img_addr(img_addr), .wgt_addr(wgt_addr),
    .mac_valid(mac_valid), .acc_first(acc_first),
    .acc_last(acc_last), .out_we(out_we), .out_addr(out_addr)
  );

  conv3x3_sequencer #(
    .IMG_W(3), .IMG_H(3), .ADDR_W(4), .OADDR_W(1)
  ) u_small (
    .clk(clk), .rst(rst), .start(start2), .hold(hold2),
    .busy(s_busy), .done(s_done), .rd_en(s_rd_en),
    .img_addr(s_img_addr), .wgt_addr(s_wgt_addr),
    .mac_valid(s_mac_valid), .acc_first(s_acc_first),
    .acc_last(s_acc_last), .out_we(s_out_we), .out_addr(s_out_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    int rel;
    bit exp_busy;
    ent_t e;
    rel = cyc - frame_s;
    if (!rst) begin
      chk("reset_zero",
          int'({busy, done, rd_en, img_addr, wgt_addr, mac_valid,
                acc_first, acc_last, out_we, out_addr}), 0);
    end else begin
      exp_busy = active && rel >= 1 && rel <= frame_done;
      chk("busy", int'(busy), int'(exp_busy));
      if (rd_en) begin
        if (qi.size() == 0) chk("unexpected_rd_en", 1, 0);
        else begin
          e = qi.pop_front();
          chk("issue_cycle", rel, e.cyc);
          chk("img_addr", int'(img_addr), e.a);
          chk("wgt_addr", int'(wgt_addr), e.b);
        end
      end else if (hold && active && rel >= 1 && qi.size() > 0) begin
        chk("held_img_addr", int'(img_addr), qi[0].a);
        chk("held_wgt_addr", int'(wgt_addr), qi[0].b);
      end
      if (mac_valid) begin
        if (qt.size() == 0) chk("unexpected_mac_valid", 1, 0);
        else begin
          e = qt.pop_front();
          chk("mac_cycle", rel, e.cyc);
          chk("acc_first", int'(acc_first), e.a);
          chk("acc_last", int'(acc_last), e.b);
        end
      end
      if (out_we) begin
        if (qw.size() == 0) chk("unexpected_out_we", 1, 0);
        else begin
          e = qw.pop_front();
          chk("we_cycle", rel, e.cyc);
          chk("out_addr", int'(out_addr), e.a);
          chk("done_tag", int'(done), e.b);
        end
      end else if (done) begin
        chk("done_without_we", 1, 0);
      end
    end
  end

  task automatic run_frame(input int pct, input int hold_tap,
                           input bit pulse, input int abort_at);
    int ia[$];
    int wa[$];
    int pa[$];
    bit pat[$];
    int issued;
    int nh;
    int k;
    int last;
    int done_c;
    bit h;
    ent_t e;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++) begin
            ia.push_back((r + kr) * W + c + kc);
            wa.push_back(kr * 3 + kc);
            pa.push_back(r * OW + c);
          end
    issued = 0;
    nh = 0;
    while (issued < T) begin
      if (hold_tap >= 0 && issued == hold_tap && nh < 3) begin
        h = 1;
        nh++;
      end else begin
        h = ($urandom_range(0, 99) < pct);
      end
      pat.push_back(h);
      if (!h) issued++;
    end
    last = pat.size();
    done_c = last + 2;
    k = 0;
    for (int c = 1; c <= last; c++) begin
      if (!pat[c-1]) begin
        e.cyc = c; e.a = ia[k]; e.b = wa[k]; e.c = 0;
        qi.push_back(e);
        e.cyc = c + 1;
        e.a = int'(k % 9 == 0);
        e.b = int'(k % 9 == 8);
        qt.push_back(e);
        if (k % 9 == 8) begin
          e.cyc = c + 2; e.a = pa[k]; e.b = int'(k == T - 1);
          qw.push_back(e);
        end
        k++;
      end
    end
    @(posedge clk);
    #1;
    start = 1;
    hold = (hold_tap == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    frame_s = cyc;
    frame_done = done_c;
    active = 1;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk);
      #1;
      if (abort_at > 0 && c == abort_at) begin
        rst = 0;
        active = 0;
        start = 0;
        hold = 0;
        qi.delete();
        qt.delete();
        qw.delete();
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        rst = 1;
        repeat (20) @(posedge clk);
        #1;
        break;
      end
      start = pulse && (c == 50 || c == done_c);
      hold = (c <= last) ? pat[c-1] : 1'($urandom_range(0, 1));
    end
    if (active) begin
      @(posedge clk);
      #1;
      active = 0;
      start = 0;
      hold = 0;
      repeat (3) @(posedge clk);
      #1;
    end
    chk("issues_left", qi.size(), 0);
    chk("tags_left", qt.size(), 0);
    chk("writes_left", qw.size(), 0);
  endtask

  initial begin
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      start = ~start;
    end
    start = 0;
    rst = 1;
    repeat (5) @(posedge clk);
    #1;

    run_frame(0, -1, 0, 0);
    run_frame(0, 4, 0, 0);
    run_frame(0, -1, 1, 0);
    run_frame(0, -1, 0, 0);
    run_frame(0, -1, 0, 100);
    run_frame(0, -1, 0, 0);
    run_frame(30, -1, 0, 0);
    run_frame(20, 0, 1, 0);

    @(posedge clk);
    #1;
    start2 = 1;
    @(posedge clk);
    #1;
    start2 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("s_rd_en", int'(s_rd_en), int'(c <= 9));
      if (c <= 9) begin
        chk("s_img_addr", int'(s_img_addr), c - 1);
        chk("s_wgt_addr", int'(s_wgt_addr), c - 1);
      end
      chk("s_out_we", int'(s_out_we), int'(c == 11));
      chk("s_done", int'(s_done), int'(c == 11));
      chk("s_busy", int'(s_busy), int'(c <= 11));
      if (c == 11) chk("s_out_addr", int'(s_out_addr), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
